// File: rtl/gpu_raster_pkg.sv
// rtl/gpu_raster_pkg.sv - shared types, defaults and vector helper for the raster interrupt scheduler
package gpu_raster_pkg;

  localparam int NUM_TRIG_DEF = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  // Vectors step by two so each trigger owns an IM2-style word slot; wraps mod 256.
  function automatic logic [7:0] vec_from_idx(input logic [7:0] base, input logic [4:0] idx);
    return base + {2'b00, idx, 1'b0};
  endfunction

endpackage

// File: rtl/raster_prio_enc.sv
// rtl/raster_prio_enc.sv - combinational lowest-index-first priority encoder
module raster_prio_enc #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [4:0]       idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = i[4:0];
    end
  end

endmodule

// File: rtl/raster_irq_ctrl.sv
// rtl/raster_irq_ctrl.sv - raster trigger interrupt scheduler; optional RASTER_IRQ_OVERRUN_EN adds sticky overrun flags
module raster_irq_ctrl
  import gpu_raster_pkg::*;
#(
  parameter int          NUM_TRIG = NUM_TRIG_DEF,
  parameter logic [7:0]  VEC_BASE = 8'h80
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic [2*NUM_TRIG-1:0] raster_HV_triggers,
  input  logic [NUM_TRIG-1:0]   irq_mask,
  input  logic                  irq_clr_all,
  input  logic                  irq_ack,
  output logic                  irq_n,
  output logic [7:0]            irq_vector,
  output logic [NUM_TRIG-1:0]   irq_pending,
  output logic [NUM_TRIG-1:0]   irq_overrun
);

  logic [NUM_TRIG-1:0] hit;
  logic [NUM_TRIG-1:0] hit_q;
  logic [NUM_TRIG-1:0] prev_hit;
  logic [NUM_TRIG-1:0] rise;
  logic [NUM_TRIG-1:0] ack_clr;
  logic [NUM_TRIG-1:0] pending_q;
  logic [NUM_TRIG-1:0] eligible;
  logic                enc_valid;
  logic [4:0]          enc_idx;
  logic [4:0]          idx_q;
  logic                ack_fire;
  logic                load_req;
  irq_state_t          state, state_n;

  // An event needs both the H and the V match of its pair.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      hit[i] = raster_HV_triggers[2*i] & raster_HV_triggers[2*i+1];
    end
  end

  // Register the match flags, then keep one more copy to find the rising edge.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hit_q    <= '0;
      prev_hit <= '0;
    end else begin
      hit_q    <= hit;
      prev_hit <= hit_q;
    end
  end

  assign rise     = hit_q & ~prev_hit;
  assign eligible = pending_q & irq_mask;

  // Clear mask for the trigger being acknowledged.
  always_comb begin
    ack_clr          = '0;
    ack_clr[idx_q]   = ack_fire;
  end

  // Pending bits latch every rise regardless of mask; a coincident set beats a clear.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_clr & ~{NUM_TRIG{irq_clr_all}}) | rise;
    end
  end

  assign irq_pending = pending_q;

  raster_prio_enc #(.WIDTH(NUM_TRIG)) u_prio (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // State, serviced index and vector registers; vector holds outside ASSERT.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      irq_vector <= VEC_BASE;
    end else begin
      state <= state_n;
      if (load_req) begin
        idx_q      <= enc_idx;
        irq_vector <= vec_from_idx(VEC_BASE, enc_idx);
      end
    end
  end

  // Request sequencing: a granted request is held until the host acknowledges it.
  always_comb begin
    state_n  = state;
    irq_n    = 1'b1;
    ack_fire = 1'b0;
    load_req = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          load_req = 1'b1;
          state_n  = ASSERT;
        end
      end
      ASSERT: begin
        irq_n = 1'b0;
        if (irq_ack) begin
          ack_fire = 1'b1;
          state_n  = HOLDOFF;
        end
      end
      HOLDOFF: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef RASTER_IRQ_OVERRUN_EN
  logic [NUM_TRIG-1:0] overrun_q;

  // A rise landing on an already pending trigger is remembered until clear-all.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (overrun_q & ~{NUM_TRIG{irq_clr_all}}) | (rise & pending_q);
    end
  end

  assign irq_overrun = overrun_q;
`else
  assign irq_overrun = '0;
`endif

endmodule

// File: tb/tb_raster_irq_ctrl.sv
// tb/tb_raster_irq_ctrl.sv - directed self-checking bench for raster_irq_ctrl
module tb_raster_irq_ctrl;

  localparam int NT = 24;

  logic          pclk;
  logic          reset;
  logic [2*NT-1:0] trig;
  logic [NT-1:0] mask;
  logic          clr_all;
  logic          ack;
  logic          irq_n;
  logic [7:0]    irq_vector;
  logic [NT-1:0] irq_pending;
  logic [NT-1:0] irq_overrun;

  int errors = 0;
  int checks = 0;

  raster_irq_ctrl #(.NUM_TRIG(NT), .VEC_BASE(8'h80)) dut (
    .pclk               (pclk),
    .reset              (reset),
    .raster_HV_triggers (trig),
    .irq_mask           (mask),
    .irq_clr_all        (clr_all),
    .irq_ack            (ack),
    .irq_n              (irq_n),
    .irq_vector         (irq_vector),
    .irq_pending        (irq_pending),
    .irq_overrun        (irq_overrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_trig(input int i, input logic v);
    trig[2*i]   = v;
    trig[2*i+1] = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_ovr9;

  initial begin
`ifdef RASTER_IRQ_OVERRUN_EN
    exp_ovr9 = 1'b1;
`else
    exp_ovr9 = 1'b0;
`endif
    reset   = 1'b0;
    trig    = '0;
    mask    = '1;
    clr_all = 1'b0;
    ack     = 1'b0;
    tick();
    tick();
    chk("rst_irq_n", irq_n, 1'b1);
    chk("rst_vector", irq_vector, 8'h80);
    chk("rst_pending", irq_pending, 24'h0);
    chk("rst_overrun", irq_overrun, 24'h0);
    reset = 1'b1;
    tick();

    // Trigger 5 alone: 2-cycle latency, vector 8A, ack releases.
    set_trig(5, 1'b1);
    tick();
    chk("t5_pend_early", irq_pending[5], 1'b0);
    tick();
    chk("t5_pend", irq_pending[5], 1'b1);
    chk("t5_irq_early", irq_n, 1'b1);
    set_trig(5, 1'b0);
    tick();
    chk("t5_irq", irq_n, 1'b0);
    chk("t5_vec", irq_vector, 8'h8A);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t5_ack_irq", irq_n, 1'b1);
    chk("t5_ack_pend", irq_pending[5], 1'b0);
    chk("t5_vec_hold", irq_vector, 8'h8A);
    tick();
    tick();
    chk("t5_quiet", irq_n, 1'b1);

    // Triggers 3 and 7 together: 3 first, then 7 after two high cycles.
    set_trig(3, 1'b1);
    set_trig(7, 1'b1);
    tick();
    tick();
    set_trig(3, 1'b0);
    set_trig(7, 1'b0);
    tick();
    chk("p37_irq", irq_n, 1'b0);
    chk("p37_vec3", irq_vector, 8'h86);
    chk("p37_pend", irq_pending, 24'h000088);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("p37_gap1", irq_n, 1'b1);
    chk("p37_pend7", irq_pending, 24'h000080);
    tick();
    chk("p37_gap2", irq_n, 1'b1);
    tick();
    chk("p37_irq7", irq_n, 1'b0);
    chk("p37_vec7", irq_vector, 8'h8E);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();

    // Masked trigger 2 stays pending until unmasked.
    mask[2] = 1'b0;
    set_trig(2, 1'b1);
    tick();
    tick();
    set_trig(2, 1'b0);
    tick();
    tick();
    chk("m2_irq_masked", irq_n, 1'b1);
    chk("m2_pend", irq_pending[2], 1'b1);
    mask[2] = 1'b1;
    tick();
    chk("m2_irq", irq_n, 1'b0);
    chk("m2_vec", irq_vector, 8'h84);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();

    // Trigger 4: a new rise lands on the same edge as its ack.
    set_trig(4, 1'b1);
    tick();
    tick();
    set_trig(4, 1'b0);
    tick();
    chk("r4_irq", irq_n, 1'b0);
    chk("r4_vec", irq_vector, 8'h88);
    set_trig(4, 1'b1);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    set_trig(4, 1'b0);
    chk("r4_ack_irq", irq_n, 1'b1);
    chk("r4_pend_kept", irq_pending[4], 1'b1);
    tick();
    tick();
    chk("r4_irq2", irq_n, 1'b0);
    chk("r4_vec2", irq_vector, 8'h88);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("r4_pend_done", irq_pending[4], 1'b0);
    tick();
    tick();

    // Trigger 9: second rise before ack, then clear-all while asserted.
    set_trig(9, 1'b1);
    tick();
    tick();
    set_trig(9, 1'b0);
    tick();
    chk("o9_irq", irq_n, 1'b0);
    chk("o9_vec", irq_vector, 8'h92);
    set_trig(9, 1'b1);
    tick();
    tick();
    set_trig(9, 1'b0);
    tick();
    chk("o9_overrun", irq_overrun[9], exp_ovr9);
    chk("o9_pend", irq_pending[9], 1'b1);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_pend", irq_pending, 24'h0);
    chk("clr_overrun", irq_overrun, 24'h0);
    chk("clr_irq_held", irq_n, 1'b0);
    chk("clr_vec_held", irq_vector, 8'h92);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("clr_ack_irq", irq_n, 1'b1);
    tick();
    tick();
    tick();
    chk("clr_no_rereq", irq_n, 1'b1);

    // Stray ack in IDLE does nothing.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("stray_ack", irq_n, 1'b1);

    // Asynchronous reset while asserted.
    set_trig(1, 1'b1);
    set_trig(6, 1'b1);
    tick();
    tick();
    set_trig(1, 1'b0);
    set_trig(6, 1'b0);
    tick();
    chk("ra_irq", irq_n, 1'b0);
    chk("ra_vec", irq_vector, 8'h82);
    #3;
    reset = 1'b0;
    #1;
    chk("ra_irq_rst", irq_n, 1'b1);
    chk("ra_pend_rst", irq_pending, 24'h0);
    chk("ra_vec_rst", irq_vector, 8'h80);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("ra_no_req", irq_n, 1'b1);
    chk("ra_pend_after", irq_pending, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raster_irq_ctrl.md
# raster_irq_ctrl

Interrupt scheduler for the raster trigger unit. Turns the 24 H/V raster-trigger pairs from the sync generator into latched per-trigger events. It masks them, arbitrates among simultaneous pending events by fixed priority, and presents one at a time to the host CPU as an active-low interrupt with an IM2-style vector and an acknowledge handshake. It sits between the sync generator's `raster_HV_triggers` output and the host bus interface.

## Interface
Parameters:
- NUM_TRIG, 24, number of H/V trigger pairs (bits 2i = H match, 2i+1 = V match)
- VEC_BASE, 8'h80, vector emitted for trigger 0

Ports:
- pclk  input  1  system pixel clock (125 MHz)
- reset  input  1  asynchronous, active-low reset
- raster_HV_triggers  input  2*NUM_TRIG  level match flags from sync generator
- irq_mask  input  NUM_TRIG  1 = trigger i may interrupt
- irq_clr_all  input  1  single-cycle pulse: clear every pending bit
- irq_ack  input  1  single-cycle pulse: host has read the vector
- irq_n  output  1  interrupt request to host, active low
- irq_vector  output  8  vector of the trigger being serviced
- irq_pending  output  NUM_TRIG  pending flags, readable by host
- irq_overrun  output  NUM_TRIG  sticky overrun flags (see Configuration)

## Operation
- Event: `hit[i] = H[2i] & V[2i+1]`. `prev_hit` is registered every pclk. `rise[i] = hit[i] & ~prev_hit[i]`.
- Pending: `rise[i]` sets `pending[i]`, whether or not mask[i] is set. It is cleared by ack of i or by irq_clr_all. When set and clear coincide, set wins.
- Eligible: `pending & irq_mask`. Priority is fixed, lowest index wins.
- FSM:
  - IDLE: if any eligible bit, latch idx = lowest eligible and go to ASSERT. Otherwise stay.
  - ASSERT: irq_n = 0 and irq_vector = VEC_BASE + 2*idx, mod 256. On irq_ack, clear pending[idx] and go to HOLDOFF. Masking or clearing idx while in ASSERT does not retract the request; the request stays until ack.
  - HOLDOFF: irq_n = 1 for one cycle, then go to IDLE.
- irq_clr_all in ASSERT clears pending bits but the FSM still waits for ack.
- irq_ack outside ASSERT is ignored.
- Reset values: irq_n = 1, irq_vector = VEC_BASE, pending = 0, overrun = 0, prev_hit = 0, FSM = IDLE. Reset asserted mid-ASSERT drops irq_n to 1 immediately (asynchronous).

## Timing
- Trigger pair both high sampled at edge t: pending[i] = 1 after edge t+1, irq_n = 0 after edge t+2. Latency is 2 pclk.
- irq_ack high at edge a: irq_n = 1 and pending[idx] = 0 after edge a. FSM is in IDLE after edge a+1. The next irq_n low is after edge a+2 at the earliest, so irq_n is high for at least 2 cycles between requests.
- irq_vector is stable for the whole of ASSERT. It holds its last value otherwise.
- Triggers held high, e.g. V held for a whole line or H held across a PIX_CLK_DIVIDER period, yield exactly one rise. A new event needs hit to go low for at least one pclk.

## Configuration
- RASTER_IRQ_OVERRUN_EN
  - Defined: `rise[i]` while `pending[i]` is already 1 sets `irq_overrun[i]`. The flag is sticky and cleared only by irq_clr_all or reset.
  - Undefined: irq_overrun is tied to 0 and no overrun logic is built.

## Structure
- Package gpu_raster_pkg:
  - NUM_TRIG default
  - FSM state enum: IDLE, ASSERT, HOLDOFF
  - function computing vector from idx
- Sub-module raster_prio_enc: combinational lowest-index-first encoder, NUM_TRIG wide. Outputs valid and 5-bit idx.

## Test plan
- Trigger 5 only: H[10]=V[11]=1 at edge t. Expect irq_n low after t+2 with vector 8'h8A. Ack at a: irq_n high after a, pending[5]=0.
- Triggers 3 and 7 rise in the same cycle, both unmasked. Expect vector 8'h86 first. After ack + HOLDOFF, expect vector 8'h8E. Expect irq_n high for 2 cycles between the two requests.
- Trigger 2 pending with mask[2]=0. Expect irq_n to stay 1 and irq_pending[2]=1. Set mask[2]=1: expect irq_n low 1 cycle later (IDLE→ASSERT) with vector 8'h84.
- Same cycle as ack of trigger 4, a new rise on trigger 4. Expect pending[4] to stay 1 and a second request to follow.
- With RASTER_IRQ_OVERRUN_EN, a second rise on trigger 9 before ack sets irq_overrun[9]=1. Without the macro, irq_overrun is 0.
- Reset pulled low while in ASSERT. Expect irq_n=1 and pending=0 immediately, with no request until a new rise.
